// File: rtl/vram_arbiter_if.sv
// Signal bundle for vram_arbiter: scanout read port, two client ports, BRAM port and status.
// The master modport is the requester/BRAM side, the slave modport is the arbiter.
interface vram_arbiter_if #(
  parameter int unsigned AW = 17,
  parameter int unsigned DW = 12
);
  logic            scan_req;
  logic [AW-1:0]   scan_addr;
  logic            scan_rvalid;
  logic [DW-1:0]   scan_rdata;
  logic [1:0]      cl_req;
  logic [1:0]      cl_we;
  logic [2*AW-1:0] cl_addr;
  logic [2*DW-1:0] cl_wdata;
  logic [1:0]      cl_gnt;
  logic [1:0]      cl_rvalid;
  logic [DW-1:0]   cl_rdata;
  logic            mem_en;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;
  logic            starve;
  logic [15:0]     conflict_cnt;

  modport master (
    output scan_req, scan_addr, cl_req, cl_we, cl_addr, cl_wdata, mem_rdata,
    input  scan_rvalid, scan_rdata, cl_gnt, cl_rvalid, cl_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, starve, conflict_cnt
  );

  modport slave (
    input  scan_req, scan_addr, cl_req, cl_we, cl_addr, cl_wdata, mem_rdata,
    output scan_rvalid, scan_rdata, cl_gnt, cl_rvalid, cl_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, starve, conflict_cnt
  );
endinterface

// File: rtl/vram_arbiter.sv
// Frame-buffer BRAM arbiter: scanout has absolute priority, two clients share round-robin.
// Define VRAM_ARB_STATS_EN to enable the scan-blocked-client conflict counter.
module vram_arbiter #(
  parameter int unsigned AW       = 17,
  parameter int unsigned DW       = 12,
  parameter int unsigned WAIT_MAX = 1023
) (
  input logic           clk,
  input logic           rst,
  vram_arbiter_if.slave bus
);
  localparam int unsigned WW = $clog2(WAIT_MAX + 1);
  typedef logic [WW-1:0] wait_t;
  localparam wait_t WaitMax = wait_t'(WAIT_MAX);

  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]    gnt_q, gnt_d;
  logic          rr_q, rr_d;
  logic          iss_scan_q, iss_scan_d;
  logic [1:0]    iss_cl_q, iss_cl_d;
  logic          scan_rv_q, scan_rv_d;
  logic [1:0]    cl_rv_q, cl_rv_d;
  wait_t [1:0]   wait_q, wait_d;
  logic          starve_q, starve_d;
  logic [1:0]    elig;
  logic          win;

  // A client granted in the current cycle is masked so a held request is not issued twice.
  assign elig = bus.cl_req & ~gnt_q;

  always_comb begin
    win         = 1'b0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    gnt_d       = 2'b00;
    rr_d        = rr_q;
    iss_scan_d  = 1'b0;
    iss_cl_d    = 2'b00;
    scan_rv_d   = iss_scan_q;
    cl_rv_d     = iss_cl_q;

    if (bus.scan_req) begin
      mem_en_d   = 1'b1;
      mem_addr_d = bus.scan_addr;
      iss_scan_d = 1'b1;
    end else if (elig != 2'b00) begin
      win         = (elig == 2'b11) ? rr_q : elig[1];
      mem_en_d    = 1'b1;
      mem_we_d    = bus.cl_we[win];
      mem_addr_d  = win ? bus.cl_addr[AW +: AW] : bus.cl_addr[0 +: AW];
      mem_wdata_d = win ? bus.cl_wdata[DW +: DW] : bus.cl_wdata[0 +: DW];
      gnt_d[win]  = 1'b1;
      rr_d        = ~win;
      iss_cl_d[win] = ~bus.cl_we[win];
    end

    for (int i = 0; i < 2; i++) begin
      if (bus.cl_req[i] && !gnt_q[i]) begin
        wait_d[i] = (wait_q[i] == WaitMax) ? WaitMax : wait_q[i] + wait_t'(1);
      end else begin
        wait_d[i] = '0;
      end
    end
    starve_d = starve_q | (wait_d[0] == WaitMax) | (wait_d[1] == WaitMax);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      gnt_q       <= 2'b00;
      rr_q        <= 1'b0;
      iss_scan_q  <= 1'b0;
      iss_cl_q    <= 2'b00;
      scan_rv_q   <= 1'b0;
      cl_rv_q     <= 2'b00;
      wait_q      <= '0;
      starve_q    <= 1'b0;
    end else begin
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      gnt_q       <= gnt_d;
      rr_q        <= rr_d;
      iss_scan_q  <= iss_scan_d;
      iss_cl_q    <= iss_cl_d;
      scan_rv_q   <= scan_rv_d;
      cl_rv_q     <= cl_rv_d;
      wait_q      <= wait_d;
      starve_q    <= starve_d;
    end
  end

`ifdef VRAM_ARB_STATS_EN
  logic [15:0] conf_q, conf_d;

  always_comb begin
    conf_d = conf_q;
    if (bus.scan_req && (elig != 2'b00) && (conf_q != 16'hFFFF)) begin
      conf_d = conf_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conf_q <= 16'h0000;
    end else begin
      conf_q <= conf_d;
    end
  end

  assign bus.conflict_cnt = conf_q;
`else
  assign bus.conflict_cnt = 16'h0000;
`endif

  assign bus.mem_en      = mem_en_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.cl_gnt      = gnt_q;
  assign bus.scan_rvalid = scan_rv_q;
  assign bus.cl_rvalid   = cl_rv_q;
  // Read data is gated so it reads 0 whenever no return is in progress, including in reset.
  assign bus.scan_rdata  = scan_rv_q ? bus.mem_rdata : '0;
  assign bus.cl_rdata    = (cl_rv_q != 2'b00) ? bus.mem_rdata : '0;
  assign bus.starve      = starve_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// Directed plus randomized bench for vram_arbiter, checked against a transaction-level model
// with a shadow copy of the frame buffer.
module tb_vram_arbiter;
  localparam int unsigned AW       = 17;
  localparam int unsigned DW       = 12;
  localparam int unsigned WAIT_MAX = 1023;

  logic clk = 1'b0;
  logic rst = 1'b1;

  vram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  vram_arbiter #(.AW(AW), .DW(DW), .WAIT_MAX(WAIT_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Single-port BRAM with a backdoor write port for preloading.
  logic [DW-1:0] bram [0:(1<<AW)-1];
  logic          bd_we   = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [DW-1:0] bd_data = '0;
  logic [DW-1:0] rdata_r = '0;

  always @(posedge clk) begin
    if (bd_we) begin
      bram[bd_addr] <= bd_data;
    end else if (bus.mem_en) begin
      if (bus.mem_we) bram[bus.mem_addr] <= bus.mem_wdata;
      else            rdata_r <= bram[bus.mem_addr];
    end
  end
  assign bus.mem_rdata = rdata_r;

  int vectors = 0;
  int errs    = 0;

  // Model of what the DUT should show in the current cycle.
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  logic          m_en, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [1:0]    m_gnt;
  int            m_rr;
  int            m_wait [2];
  logic          m_starve;
  int            m_conf;
  int            m_is_kind, m_rv_kind;  // 0 none, 1 scan, 2 client 0, 3 client 1
  logic [DW-1:0] m_is_data, m_rv_data;

  task automatic model_reset();
    m_en = 0; m_we = 0; m_addr = '0; m_wdata = '0; m_gnt = 2'b00; m_rr = 0;
    m_wait[0] = 0; m_wait[1] = 0; m_starve = 0; m_conf = 0;
    m_is_kind = 0; m_rv_kind = 0; m_is_data = '0; m_rv_data = '0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".mem_en"}, 32'(bus.mem_en), 0);
    chk({tag, ".mem_we"}, 32'(bus.mem_we), 0);
    chk({tag, ".mem_addr"}, 32'(bus.mem_addr), 0);
    chk({tag, ".mem_wdata"}, 32'(bus.mem_wdata), 0);
    chk({tag, ".cl_gnt"}, 32'(bus.cl_gnt), 0);
    chk({tag, ".scan_rvalid"}, 32'(bus.scan_rvalid), 0);
    chk({tag, ".scan_rdata"}, 32'(bus.scan_rdata), 0);
    chk({tag, ".cl_rvalid"}, 32'(bus.cl_rvalid), 0);
    chk({tag, ".cl_rdata"}, 32'(bus.cl_rdata), 0);
    chk({tag, ".starve"}, 32'(bus.starve), 0);
    chk({tag, ".conflict_cnt"}, 32'(bus.conflict_cnt), 0);
  endtask

  // Predict the effect of the coming rising edge, advance one cycle, compare at the negedge.
  task automatic tick();
    logic [1:0]    elig;
    logic [1:0]    n_gnt;
    logic [1:0]    exp_crv;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            w;
    elig      = bus.cl_req & ~m_gnt;
    n_gnt     = 2'b00;
    m_rv_kind = m_is_kind;
    m_rv_data = m_is_data;
    m_is_kind = 0;
    m_en      = 0;
    m_we      = 0;
    if (bus.scan_req) begin
      m_en      = 1;
      m_addr    = bus.scan_addr;
      m_is_kind = 1;
      m_is_data = shadow[bus.scan_addr];
    end else if (elig != 2'b00) begin
      w        = (elig == 2'b11) ? m_rr : (elig[1] ? 1 : 0);
      a        = bus.cl_addr[w*AW +: AW];
      d        = bus.cl_wdata[w*DW +: DW];
      m_en     = 1;
      m_we     = bus.cl_we[w];
      m_addr   = a;
      n_gnt[w] = 1'b1;
      m_rr     = 1 - w;
      if (m_we) begin
        m_wdata   = d;
        shadow[a] = d;
      end else begin
        m_is_kind = 2 + w;
        m_is_data = shadow[a];
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (bus.cl_req[i] && !m_gnt[i]) m_wait[i] = (m_wait[i] >= WAIT_MAX) ? WAIT_MAX : m_wait[i] + 1;
      else                            m_wait[i] = 0;
      if (m_wait[i] == WAIT_MAX) m_starve = 1;
    end
`ifdef VRAM_ARB_STATS_EN
    if (bus.scan_req && elig != 2'b00 && m_conf < 65535) m_conf++;
`endif
    m_gnt = n_gnt;
    @(posedge clk);
    @(negedge clk);
    exp_crv = {m_rv_kind == 3, m_rv_kind == 2};
    chk("mem_en", 32'(bus.mem_en), 32'(m_en));
    chk("mem_we", 32'(bus.mem_we), 32'(m_we));
    chk("mem_addr", 32'(bus.mem_addr), 32'(m_addr));
    if (m_we) chk("mem_wdata", 32'(bus.mem_wdata), 32'(m_wdata));
    chk("cl_gnt", 32'(bus.cl_gnt), 32'(m_gnt));
    chk("scan_rvalid", 32'(bus.scan_rvalid), 32'(m_rv_kind == 1));
    if (m_rv_kind == 1) chk("scan_rdata", 32'(bus.scan_rdata), 32'(m_rv_data));
    chk("cl_rvalid", 32'(bus.cl_rvalid), 32'(exp_crv));
    if (m_rv_kind >= 2) chk("cl_rdata", 32'(bus.cl_rdata), 32'(m_rv_data));
    chk("starve", 32'(bus.starve), 32'(m_starve));
    chk("conflict_cnt", 32'(bus.conflict_cnt), 32'(m_conf));
  endtask

  task automatic idle_inputs();
    bus.scan_req = 0; bus.scan_addr = '0; bus.cl_req = 2'b00; bus.cl_we = 2'b00;
    bus.cl_addr = '0; bus.cl_wdata = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] v;
    idle_inputs();
    model_reset();
    // Preload addresses 0..255 while held in reset.
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      v = (i == 'h10) ? 12'hABC : DW'($urandom);
      bd_we = 1; bd_addr = AW'(i); bd_data = v; shadow[i] = v;
    end
    @(negedge clk);
    bd_we = 0;
    chk_zero("reset");
    rst = 0;

    // Single scan read.
    bus.scan_req = 1; bus.scan_addr = 'h10;
    tick();
    chk("t1.mem_en", 32'(bus.mem_en), 1);
    chk("t1.mem_addr", 32'(bus.mem_addr), 'h10);
    chk("t1.cl_gnt", 32'(bus.cl_gnt), 0);
    bus.scan_req = 0;
    tick();
    chk("t1.scan_rvalid", 32'(bus.scan_rvalid), 1);
    chk("t1.scan_rdata", 32'(bus.scan_rdata), 'hABC);

    // Both clients write continuously: grants alternate 0,1,0,1.
    bus.cl_req = 2'b11; bus.cl_we = 2'b11;
    bus.cl_addr = {AW'('h200), AW'('h100)};
    bus.cl_wdata = {12'h222, 12'h111};
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("t2.gnt_alt", 32'(bus.cl_gnt), (k % 2 == 0) ? 1 : 2);
    end
    bus.cl_req = 2'b00;
    tick();
    tick();
    chk("t2.bram100", 32'(bram['h100]), 'h111);
    chk("t2.bram200", 32'(bram['h200]), 'h222);

    // Scan and client 0 read in the same cycle.
    bus.scan_req = 1; bus.scan_addr = 'h10;
    bus.cl_req = 2'b01; bus.cl_we = 2'b00; bus.cl_addr = {AW'(0), AW'('h100)};
    tick();
    chk("t5.gnt_blocked", 32'(bus.cl_gnt), 0);
    bus.scan_req = 0;
    tick();
    chk("t5.cl_gnt", 32'(bus.cl_gnt), 1);
    chk("t5.scan_rvalid", 32'(bus.scan_rvalid), 1);
    chk("t5.scan_rdata", 32'(bus.scan_rdata), 'hABC);
    bus.cl_req = 2'b00;
    tick();
    chk("t5.cl_rvalid", 32'(bus.cl_rvalid), 1);
    chk("t5.scan_rv_off", 32'(bus.scan_rvalid), 0);
    chk("t5.cl_rdata", 32'(bus.cl_rdata), 'h111);

    // Client 1 read interrupted by reset in the issue cycle.
    bus.cl_req = 2'b10; bus.cl_we = 2'b00; bus.cl_addr = {AW'('h200), AW'(0)};
    tick();
    chk("t4.cl_gnt", 32'(bus.cl_gnt), 2);
    rst = 1;
    #1;
    chk_zero("t4.async_rst");
    model_reset();
    bus.cl_req = 2'b00;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t4.no_rvalid", 32'(bus.cl_rvalid), 0);
    end

    // Scan held for 1100 cycles starves client 0.
    bus.cl_req = 2'b01; bus.cl_we = 2'b00; bus.cl_addr = {AW'(0), AW'('h10)};
    bus.scan_req = 1;
    for (int k = 1; k <= 1100; k++) begin
      bus.scan_addr = AW'(k % 256);
      tick();
      if (k == 1000) chk("t3.starve_early", 32'(bus.starve), 0);
    end
    chk("t3.starve_set", 32'(bus.starve), 1);
`ifdef VRAM_ARB_STATS_EN
    chk("t3.conflict_cnt", 32'(bus.conflict_cnt), 1100);
`else
    chk("t3.conflict_cnt", 32'(bus.conflict_cnt), 0);
`endif
    bus.scan_req = 0;
    tick();
    chk("t3.late_gnt", 32'(bus.cl_gnt), 1);
    bus.cl_req = 2'b00;
    tick();
    tick();
    chk("t3.starve_sticky", 32'(bus.starve), 1);

    // Randomized traffic; clients hold each request until granted.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!bus.cl_req[i] || m_gnt[i]) begin
          bus.cl_req[i] = $urandom_range(1, 0) == 1;
          bus.cl_we[i] = $urandom_range(1, 0) == 1;
          bus.cl_addr[i*AW +: AW] = AW'($urandom_range(255, 0));
          bus.cl_wdata[i*DW +: DW] = DW'($urandom);
        end
      end
      bus.scan_req = $urandom_range(2, 0) == 0;
      bus.scan_addr = AW'($urandom_range(255, 0));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one single-port synchronous frame-buffer BRAM (1-cycle read latency) between three requesters.
- Requesters: the VGA scanout reader and two game-logic clients (client 0 = map/background writer, client 1 = player/sprite writer).
- Scanout has absolute priority, so the display never tears. The two clients are round-robin arbitrated.
- A sticky starvation flag reports a client that waited too long.

Parameters:
- AW, 17, address width (320x240 = 76800 words)
- DW, 12, data width (RGB 4:4:4)
- WAIT_MAX, 1023, client wait cycles that set the starvation flag

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- scan_req  in  1  scanout read request
- scan_addr  in  AW  scanout read address
- scan_rvalid  out  1  scanout read data valid
- scan_rdata  out  DW  scanout read data
- cl_req  in  2  client request, bit i = client i
- cl_we  in  2  client write enable (1 = write, 0 = read)
- cl_addr  in  2*AW  client addresses; client i at [i*AW +: AW]
- cl_wdata  in  2*DW  client write data; client i at [i*DW +: DW]
- cl_gnt  out  2  one-cycle grant pulse
- cl_rvalid  out  2  read-data-valid pulse per client
- cl_rdata  out  DW  read data shared by both clients
- mem_en  out  1  BRAM enable
- mem_we  out  1  BRAM write enable
- mem_addr  out  AW  BRAM address
- mem_wdata  out  DW  BRAM write data
- mem_rdata  in  DW  BRAM read data, valid one cycle after mem_en
- starve  out  1  sticky starvation flag
- conflict_cnt  out  16  scan-blocked-client cycle count (see Optional Feature)

Behaviour:
- Reset (asynchronous, immediate): all outputs 0, round-robin pointer rr=0, wait counters 0, read-valid pipeline cleared. An in-flight read is dropped: no rvalid after reset.
- Requests are sampled at the rising edge that ends cycle n.
- Cycle n+1: registered mem_en/mem_we/mem_addr/mem_wdata, plus cl_gnt[i] if a client won.
- Cycle n+2: read data returns.
  - Scanout: scan_rvalid=1, scan_rdata=mem_rdata.
  - Client i: cl_rvalid[i]=1, cl_rdata=mem_rdata.
- Writes produce cl_gnt but never cl_rvalid.
- Priority in each sampling cycle:
  1. If scan_req=1, scanout wins. mem_we=0, no cl_gnt.
  2. Otherwise one requesting client wins. If both request, client rr wins. After client i is granted, rr <= ~i.
  3. If nothing is requested, mem_en=0 and mem_addr/mem_wdata hold their previous values.
- Grant masking: a client whose cl_gnt is high in a cycle is ignored at that cycle's sampling edge. This prevents a double issue while the client drops req, so per-client peak rate is one op every 2 cycles.
- A client must hold req, we, addr and wdata stable until it sees cl_gnt.
- Scanout may request every cycle. Back-to-back scan reads give back-to-back scan_rvalid.
- The scanout port cannot write.
- Wait counter, per client:
  - Increments each cycle req=1 and gnt=0, saturating at WAIT_MAX.
  - Clears on gnt or on req=0.
  - Reaching WAIT_MAX sets starve=1, which stays set until rst.
- Simultaneous scan_req and both client requests: scan is served; both clients wait and rr is unchanged.
- Only one of scan_rvalid/cl_rvalid bits is high in any cycle.

Optional Feature:
- Macro: VRAM_ARB_STATS_EN.
- Defined: conflict_cnt increments each cycle where scan_req=1 and at least one unmasked cl_req=1. It saturates at 16'hFFFF and resets to 0.
- Undefined: the counter logic is absent, conflict_cnt is tied to 0, and the port is still present.

Test Plan:
- scan_req=1, scan_addr=0x00010 for one cycle, BRAM preloaded 0x00010=12'hABC -> mem_en=1, mem_addr=0x00010 in n+1; scan_rvalid=1, scan_rdata=12'hABC in n+2; cl_gnt stays 0.
- Both clients write continuously (client 0: 0x00100 data 12'h111; client 1: 0x00200 data 12'h222), no scan, from reset -> grants alternate 0,1,0,1, each client granted at most every 2nd cycle; BRAM holds 111/222.
- scan_req held high 1100 cycles while cl_req[0]=1 -> cl_gnt[0]=0 throughout, starve=1 after 1023 wait cycles and still 1 after scan_req drops; with VRAM_ARB_STATS_EN, conflict_cnt=1100.
- Client 1 read of 0x00200 issued, rst pulsed in cycle n+1 -> all outputs 0 immediately; no cl_rvalid after rst releases.
- Client 0 read of 0x00100 and scan read of 0x00010 in the same cycle -> scan served first with scan_rvalid in n+2; client 0 granted the next cycle with cl_rvalid[0]=1, cl_rdata=12'h111 one cycle later; never two rvalids in one cycle.
